// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared widths, readout states and record word selection for trace capture
package trace_pkg;

    localparam int REC_W  = 96;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } rd_state_t;

    // Record layout is {pc, instruction, alu_result}; idx 0 selects pc.
    function automatic logic [WORD_W-1:0] rec_word(input logic [REC_W-1:0] rec,
                                                    input logic [1:0]       idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = rec[REC_W-1 -: WORD_W];
            2'd1:    w = rec[REC_W-WORD_W-1 -: WORD_W];
            default: w = rec[WORD_W-1:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous record FIFO exposing the head and the entry behind it
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      push,
    input  logic [REC_W-1:0]          push_data,
    input  logic                      pop,
    output logic [REC_W-1:0]          head_data,
    output logic [REC_W-1:0]          next_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr];
    assign next_data = mem[rd_ptr + PTR_ONE];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - CPU trace qualification, record buffering and word-serial readout
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cap_en,
    input  logic                      flush,
    input  logic [31:0]               debug_pc,
    input  logic [31:0]               debug_instruction,
    input  logic [31:0]               debug_alu_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic                      out_last,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [CNT_W-1:0]          overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      CNT_ONE = 1;
    localparam logic [CNT_W-1:0] OVF_ONE = 1;

    rd_state_t        state;
    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] head_data;
    logic [REC_W-1:0] next_data;
    logic [REC_W-1:0] next_rec;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      last_pc;
    logic             pc_valid;
    logic             cap_en_q;
    logic             started;
    logic             qualify;
    logic             accept;
    logic             drop;
    logic             xfer;
    logic             pop;
    logic             more;

    assign rec_in = {debug_pc, debug_instruction, debug_alu_result};

    // A rising cap_en masks the stored PC so the first enabled sample always qualifies.
    assign qualify = started && cap_en && !flush &&
                     (!(pc_valid && cap_en_q) || (debug_pc != last_pc));

    assign xfer   = out_valid && out_ready;
    assign pop    = xfer && (state == ST_W2);
    assign accept = qualify && (!fifo_full || pop);
    assign drop   = qualify && !accept;

    // After a W2 pop the next record is either already stored or arriving this cycle.
    assign more     = (fifo_count > CNT_ONE) || accept;
    assign next_rec = (fifo_count > CNT_ONE) ? next_data : rec_in;

    trace_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (qualify),
        .push_data (rec_in),
        .pop       (pop),
        .head_data (head_data),
        .next_data (next_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started      <= 1'b0;
            cap_en_q     <= 1'b0;
            last_pc      <= '0;
            pc_valid     <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            started  <= 1'b1;
            cap_en_q <= cap_en;
            if (flush) begin
                pc_valid     <= 1'b0;
                overflow_cnt <= '0;
            end else begin
                if (qualify) begin
                    last_pc  <= debug_pc;
                    pc_valid <= 1'b1;
                end
                if (drop && (overflow_cnt != '1)) begin
                    overflow_cnt <= overflow_cnt + OVF_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state     <= ST_W0;
                        out_valid <= 1'b1;
                        out_data  <= rec_word(head_data, 2'd0);
                        out_last  <= 1'b0;
                    end
                end
                ST_W0: begin
                    if (out_ready) begin
                        state    <= ST_W1;
                        out_data <= rec_word(head_data, 2'd1);
                    end
                end
                ST_W1: begin
                    if (out_ready) begin
                        state    <= ST_W2;
                        out_data <= rec_word(head_data, 2'd2);
                        out_last <= 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_last <= 1'b0;
                        if (more) begin
                            state    <= ST_W0;
                            out_data <= rec_word(next_rec, 2'd0);
                        end else begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - scoreboard bench for trace_capture directed scenarios
module tb_trace_capture;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cap_en = 1'b0;
    logic              flush = 1'b0;
    logic [31:0]       debug_pc = '0;
    logic [31:0]       debug_instruction = '0;
    logic [31:0]       debug_alu_result = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_data;
    logic              out_last;
    logic [4:0]        fifo_count;
    logic [CNT_W-1:0]  overflow_cnt;

    logic [32:0] exp_q [$];
    logic [32:0] e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_data = '0;

    trace_capture #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cap_en            (cap_en),
        .flush             (flush),
        .debug_pc          (debug_pc),
        .debug_instruction (debug_instruction),
        .debug_alu_result  (debug_alu_result),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .fifo_count        (fifo_count),
        .overflow_cnt      (overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'hC0DE_0000 | pc;
    endfunction

    function automatic logic [31:0] alu_of(input logic [31:0] pc);
        return 32'hA100_0000 + pc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rec(input logic [31:0] pc);
        exp_q.push_back({1'b0, pc});
        exp_q.push_back({1'b0, ins_of(pc)});
        exp_q.push_back({1'b1, alu_of(pc)});
    endtask

    task automatic sample(input logic [31:0] pc, input bit captured);
        debug_pc          = pc;
        debug_instruction = ins_of(pc);
        debug_alu_result  = alu_of(pc);
        if (captured) expect_rec(pc);
        step();
    endtask

    task automatic drain(input int bound, input bit rnd);
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < bound) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            else     out_ready = 1'b1;
            step();
            k++;
        end
        if (k >= bound) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
        end
        out_ready = 1'b0;
    endtask

    // Monitor: compares every transfer against the scoreboard and checks stall stability.
    always @(negedge clk) begin
        if (prev_valid && !prev_ready && out_valid) begin
            check("stall_hold", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got 0x%0h, expected none", out_data);
            end else begin
                e = exp_q.pop_front();
                check("word", out_data, e[31:0]);
                check("last", 32'(out_last), 32'(e[32]));
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow_cnt), 32'd0);
        #2 rst = 1'b1;
        step();

        // Three consecutive PCs with a free-running consumer.
        out_ready = 1'b1;
        cap_en = 1'b1;
        sample(32'h00, 1'b1);
        sample(32'h04, 1'b1);
        sample(32'h08, 1'b1);
        cap_en = 1'b0;
        drain(200, 1'b0);

        // Repeated PC is captured once.
        out_ready = 1'b0;
        cap_en = 1'b1;
        sample(32'h10, 1'b1);
        repeat (4) sample(32'h10, 1'b0);
        sample(32'h14, 1'b1);
        cap_en = 1'b0;
        step();
        step();
        check("dup_count", 32'(fifo_count), 32'd2);
        check("dup_valid", 32'(out_valid), 32'd1);
        check("dup_data", out_data, 32'h10);
        drain(200, 1'b0);

        // Overflow: 20 PCs into 16 entries.
        cap_en = 1'b1;
        for (int i = 0; i < 20; i++) sample(32'h100 + 32'(4 * i), i < 16);
        cap_en = 1'b0;
        step();
        check("full_count", 32'(fifo_count), 32'd16);
        check("full_ovf", 32'(overflow_cnt), 32'd4);
        out_ready = 1'b1;
        step();
        step();
        cap_en = 1'b1;
        sample(32'h200, 1'b1);
        cap_en = 1'b0;
        out_ready = 1'b0;
        step();
        check("popsame_count", 32'(fifo_count), 32'd16);
        check("popsame_ovf", 32'(overflow_cnt), 32'd4);
        drain(500, 1'b0);

        // Random back-pressure.
        cap_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            sample(32'h300 + 32'(4 * i), 1'b1);
        end
        cap_en = 1'b0;
        drain(500, 1'b1);

        // Flush while W1 is presented.
        out_ready = 1'b0;
        cap_en = 1'b1;
        sample(32'h400, 1'b1);
        sample(32'h404, 1'b1);
        cap_en = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("preflush_ovf", 32'(overflow_cnt), 32'd4);
        check("preflush_data", out_data, ins_of(32'h400));
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_count", 32'(fifo_count), 32'd0);
        check("flush_ovf", 32'(overflow_cnt), 32'd0);
        step();
        check("flush_idle", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-W1, then recapture of the same PC.
        cap_en = 1'b1;
        sample(32'h04, 1'b1);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", out_data, 32'd0);
        check("arst_last", 32'(out_last), 32'd0);
        check("arst_count", 32'(fifo_count), 32'd0);
        exp_q.delete();
        step();
        #2 rst = 1'b1;
        step();
        check("first_edge_count", 32'(fifo_count), 32'd0);
        expect_rec(32'h04);
        step();
        check("recap_count", 32'(fifo_count), 32'd1);
        cap_en = 1'b0;
        drain(200, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DEPTH, default 16, record FIFO depth; SHALL be a power of two, at least 2.
REQ-002 Parameter CNT_W, default 16, overflow counter width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 cap_en  input  1  capture enable.
REQ-006 flush  input  1  synchronous clear of all buffered trace state.
REQ-007 debug_pc  input  32  CPU program counter of the retiring cycle.
REQ-008 debug_instruction  input  32  instruction at debug_pc.
REQ-009 debug_alu_result  input  32  ALU result for that instruction.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  consumer accepts the word; transfer occurs when out_valid and out_ready are both 1.
REQ-012 out_data  output  32  serialized trace word.
REQ-013 out_last  output  1  marks the final word of a record.
REQ-014 fifo_count  output  log2(DEPTH)+1  number of records currently stored.
REQ-015 overflow_cnt  output  CNT_W  records dropped because the FIFO was full; saturates.

Function
REQ-016 Record = {pc, instruction, alu_result}, 96 bits, sampled from the debug inputs at a rising edge.
REQ-017 Capture condition: cap_en=1, flush=0, and either no PC has been captured since reset/flush/cap_en rising, or debug_pc differs from the last captured PC.
REQ-018 A qualifying sample SHALL update the last-captured PC even when the record is dropped.
REQ-019 A qualifying sample SHALL be pushed if the FIFO is not full. If the FIFO is full, it SHALL be pushed only if a record pop completes in the same cycle. Otherwise it SHALL be dropped and overflow_cnt incremented, saturating at all-ones.
REQ-020 The cap_en low-to-high edge SHALL invalidate the last-captured PC, so the first sample after enabling always qualifies.
REQ-021 Readout FSM states: IDLE, W0, W1, W2.
  - IDLE→W0 when fifo_count>0.
  - W0 emits pc; W1 emits instruction; W2 emits alu_result with out_last=1.
  - Each state advances only on a transfer.
  - From W2: go to W0 if another record remains after the pop, else to IDLE.
REQ-022 The head record SHALL be popped on the transfer cycle of W2.
REQ-023 out_valid SHALL be 1 exactly in W0/W1/W2. out_data and out_last SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-024 Latency: a record pushed into an empty FIFO at edge N SHALL produce out_valid=1 with its pc after edge N+1.
REQ-025 out_ready SHALL be ignored when out_valid=0.
REQ-026 flush=1 SHALL, at the next edge:
  - empty the FIFO;
  - force the FSM to IDLE and drop any partially sent record;
  - invalidate the last-captured PC;
  - clear overflow_cnt.
  Flush SHALL take priority over a simultaneous capture or transfer.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH. fifo_count SHALL equal pushes minus pops, range 0..DEPTH.

Reset
REQ-028 While rst=0, out_valid, out_last, out_data, fifo_count, overflow_cnt and the FIFO pointers SHALL be 0. The FSM SHALL be in IDLE, and the last-captured-PC valid flag SHALL be 0.
REQ-029 Reset assertion mid-record SHALL discard that record. FIFO storage contents need not be reset.
REQ-030 Deassertion of reset SHALL be synchronized to clk by the integrating top level. No capture SHALL occur on the first edge after deassertion.

Structure
REQ-031 Shared package trace_pkg SHALL hold the REC_W=96 and WORD_W=32 constants and the readout state enumeration.
REQ-032 Record storage SHALL be a sub-module, trace_fifo: synchronous, 96-bit wide, DEPTH entries, with full/empty/count outputs. trace_capture SHALL contain the qualification logic, counters and readout FSM.

Verification
REQ-033 Reset, then cap_en=1 with pc=0x00, 0x04, 0x08 and out_ready=1 → 9 words in order pc, instruction, alu per record; out_last=1 on words 3, 6 and 9.
REQ-034 pc held at 0x10 for 5 cycles, then 0x14 → exactly 2 records captured; fifo_count peaks at 2 with out_ready=0.
REQ-035 out_ready=0, DEPTH=16, 20 distinct PCs → fifo_count=16 and overflow_cnt=4; draining delivers the first 16 PCs unchanged.
REQ-036 FIFO full, W2 transfer coincides with a new qualifying PC → record accepted, fifo_count stays 16, overflow_cnt unchanged.
REQ-037 Toggle out_ready randomly → out_data stable during every stall, no word lost or duplicated; then flush during W1 → next cycle out_valid=0, fifo_count=0, overflow_cnt=0.
REQ-038 Assert rst=0 asynchronously mid-W1 → outputs clear immediately without a clock edge. After release, the same pc=0x04 is captured again.
